voice_mixer: RTL and testbench
==============================

# voice_mixer

Time-multiplexed mixer sitting directly downstream of the per-voice oscillators. On each sample tick it snapshots all oscillator outputs, sums the enabled voices one per clock into a wide accumulator, applies a master gain, and rescales to the output width with saturation. It then holds the mixed sample behind a valid/ready handshake for the DAC serializer.

## Interface
- VOICES, 8: number of oscillator inputs (power of two, ≥2)
- IN_WIDTH, 32: width of each signed oscillator sample (oscillator WIDTH + `FIXED_POINT)
- OUT_WIDTH, 24: width of the signed mixed output sample (< IN_WIDTH)

Ports:
- clk  in  1  system clock; all state on its rising edge
- rst  in  1  asynchronous, active-high reset
- sample_tick  in  1  single-cycle pulse at the sample rate; requests one mixed sample
- voices  in  VOICES×IN_WIDTH  signed oscillator outputs; voice i is at index i
- voice_enable  in  VOICES  per-voice include mask
- master_gain  in  8  unsigned Q1.7 gain; 128 = unity, 255 ≈ 1.99
- out_sample  out  OUT_WIDTH  signed mixed sample
- out_valid  out  1  out_sample holds an untransferred sample
- out_ready  in  1  downstream accepts out_sample
- clip  out  1  registered with out_sample; 1 = this sample saturated
- overrun  out  1  one-cycle pulse; a sample_tick was dropped

## Operation
- States: IDLE, ACCUM, SCALE, HOLD.
- IDLE: on sample_tick, capture voices, voice_enable and master_gain into snapshot registers, clear the accumulator and voice index, and go to ACCUM.
- ACCUM: each cycle, acc += snapshot voice[idx] if its enable bit is set, else += 0. idx increments. After idx = VOICES−1 is added, go to SCALE.
- Accumulator width ACC_W = IN_WIDTH + clog2(VOICES), signed. It never overflows.
- SCALE, single cycle:
  - p = acc × {0, gain}, signed, ACC_W+9 bits.
  - s = p >>> (7 + IN_WIDTH − OUT_WIDTH), arithmetic shift (floor toward −∞).
  - Saturate s to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - Register out_sample and clip (1 iff saturation was applied). Set out_valid. Go to HOLD.
- HOLD: out_sample, clip and out_valid stay stable until out_valid && out_ready at a clock edge. That edge clears out_valid and returns to IDLE.
- Tick on the same edge as a HOLD transfer: accepted. It snapshots and goes directly to ACCUM, with no overrun.
- Tick in ACCUM, SCALE, or in HOLD without a transfer: dropped. overrun pulses high for one cycle. In-flight and held data are unaffected.
- Live voices/voice_enable/master_gain changes after the snapshot do not affect the sample in progress.

## Timing
- Reset (async assert, sync deassert): state IDLE; out_sample = 0, out_valid = 0, clip = 0, overrun = 0; accumulator and snapshots = 0.
- Latency: tick sampled at edge E0. Voices accumulate on edges E1..E_VOICES. SCALE registers the output at E_(VOICES+1), so out_valid is high VOICES+1 cycles after the tick edge (9 for VOICES=8).
- Throughput: one sample per VOICES+2 cycles when out_ready is held high. Tick spacing below that raises overrun.
- out_ready is allowed high before out_valid. A transfer occurs only on an edge where both are high.
- out_ready has no combinational path to any output.
- rst asserted mid-ACCUM/SCALE/HOLD: the sample is discarded and out_valid falls immediately. The next tick after deassert produces a correct sample.

## Test plan
- Unity sum: VOICES=8, all enabled, each voice = 1000, gain 128, out_ready = 1 → out_sample = 31 (8000>>>8), clip = 0. out_valid is high exactly 9 cycles after the tick edge, for 1 cycle.
- Saturation: all voices 0x7FFFFFFF, gain 255 → out_sample = 0x7FFFFF, clip = 1. All voices 0x80000000 → out_sample = 0x800000, clip = 1.
- Floor rounding and masking: voice0 = −1, others 0 → −1. voice_enable = 0x01, voice0 = 512, others 1,000,000 → 2. Changing voices during ACCUM leaves the result unchanged.
- Back-pressure:
  - Hold out_ready = 0 for 20 cycles after valid, and tick during HOLD → overrun pulses 1 cycle; out_sample and clip are unchanged.
  - Raise out_ready together with a new tick → transfer occurs, no overrun, next sample is valid 9 cycles later.
- Reset mid-ACCUM: assert rst at idx = 3 → all outputs 0 immediately, no valid appears. The next tick yields the correct sum.
- Tick 5 cycles after a previous tick (during ACCUM) → overrun pulses and the first sample completes correctly. Exactly one valid sample results.

Source files
------------

// File: rtl/voice_mixer_if.sv
`default_nettype none
// ============================================================================
//  voice_mixer_if : oscillator snapshot inputs and mixed-sample handshake
//  Revision 1.0
// ============================================================================
interface voice_mixer_if #(
  parameter int VOICES    = 8,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 24
);
  logic                               sample_tick;
  logic [VOICES-1:0][IN_WIDTH-1:0]    voices;
  logic [VOICES-1:0]                  voice_enable;
  logic [7:0]                         master_gain;
  logic [OUT_WIDTH-1:0]               out_sample;
  logic                               out_valid;
  logic                               out_ready;
  logic                               clip;
  logic                               overrun;

  // master is the mixer itself; slave is the oscillator/DAC side
  modport master (
    input  sample_tick, voices, voice_enable, master_gain, out_ready,
    output out_sample, out_valid, clip, overrun
  );
  modport slave (
    output sample_tick, voices, voice_enable, master_gain, out_ready,
    input  out_sample, out_valid, clip, overrun
  );
endinterface
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
//  voice_mixer : sequential sum of enabled voices, Q1.7 gain, saturating rescale
//  Revision 1.0
// ============================================================================
module voice_mixer #(
  parameter int VOICES    = 8,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 24
) (
  input  logic          clk,
  input  logic          rst,
  voice_mixer_if.master bus
);
  localparam int IDX_W  = $clog2(VOICES);
  localparam int ACC_W  = IN_WIDTH + IDX_W;
  localparam int PROD_W = ACC_W + 9;
  localparam int SHIFT  = 7 + IN_WIDTH - OUT_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic [VOICES-1:0][IN_WIDTH-1:0] snap_voices_q, snap_voices_d;
  logic [VOICES-1:0]               snap_en_q, snap_en_d;
  logic [7:0]                      snap_gain_q, snap_gain_d;
  logic [OUT_WIDTH-1:0]            out_sample_q, out_sample_d;
  logic                            out_valid_q, out_valid_d;
  logic                            clip_q, clip_d;
  logic                            overrun_q, overrun_d;

  logic [IN_WIDTH-1:0]             cur_voice;
  logic signed [ACC_W-1:0]         voice_term;
  logic signed [PROD_W-1:0]        prod;
  logic signed [PROD_W-1:0]        shifted;
  logic [PROD_W-OUT_WIDTH:0]       upper;
  logic [OUT_WIDTH-1:0]            sat_sample;
  logic                            sat_clip;
  logic                            transfer;
  logic                            take_tick;

  always_comb begin
    cur_voice  = snap_voices_q[idx_q];
    voice_term = snap_en_q[idx_q] ? {{IDX_W{cur_voice[IN_WIDTH-1]}}, cur_voice} : '0;
    prod       = PROD_W'(acc_q) * PROD_W'($signed({1'b0, snap_gain_q}));
    shifted    = prod >>> SHIFT;
    // In range only when every bit above the output sign bit copies it
    upper      = shifted[PROD_W-1:OUT_WIDTH-1];
    sat_clip   = !((&upper) || !(|upper));
    if (!sat_clip) begin
      sat_sample = shifted[OUT_WIDTH-1:0];
    end else if (shifted[PROD_W-1]) begin
      sat_sample = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sat_sample = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    snap_voices_d = snap_voices_q;
    snap_en_d     = snap_en_q;
    snap_gain_d   = snap_gain_q;
    out_sample_d  = out_sample_q;
    out_valid_d   = out_valid_q;
    clip_d        = clip_q;
    overrun_d     = 1'b0;
    take_tick     = 1'b0;
    transfer      = out_valid_q && bus.out_ready;

    case (state_q)
      IDLE: begin
        if (bus.sample_tick) take_tick = 1'b1;
      end
      ACCUM: begin
        acc_d = acc_q + voice_term;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = SCALE;
        if (bus.sample_tick) overrun_d = 1'b1;
      end
      SCALE: begin
        out_sample_d = sat_sample;
        clip_d       = sat_clip;
        out_valid_d  = 1'b1;
        state_d      = HOLD;
        if (bus.sample_tick) overrun_d = 1'b1;
      end
      HOLD: begin
        if (transfer) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (bus.sample_tick) take_tick = 1'b1;
        end else if (bus.sample_tick) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick taken back-to-back with a transfer skips IDLE entirely
    if (take_tick) begin
      snap_voices_d = bus.voices;
      snap_en_d     = bus.voice_enable;
      snap_gain_d   = bus.master_gain;
      acc_d         = '0;
      idx_d         = '0;
      state_d       = ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      snap_voices_q <= '0;
      snap_en_q     <= '0;
      snap_gain_q   <= '0;
      out_sample_q  <= '0;
      out_valid_q   <= 1'b0;
      clip_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      snap_voices_q <= snap_voices_d;
      snap_en_q     <= snap_en_d;
      snap_gain_q   <= snap_gain_d;
      out_sample_q  <= out_sample_d;
      out_valid_q   <= out_valid_d;
      clip_q        <= clip_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.clip       = clip_q;
  assign bus.overrun    = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// ============================================================================
//  tb_voice_mixer : directed and randomized checks against a sample-level model
//  Revision 1.0
// ============================================================================
module tb_voice_mixer;
  localparam int V  = 8;
  localparam int IW = 32;
  localparam int OW = 24;

  typedef logic [V-1:0][IW-1:0] vvec_t;

  logic clk;
  logic rst;
  voice_mixer_if #(.VOICES(V), .IN_WIDTH(IW), .OUT_WIDTH(OW)) vif ();

  voice_mixer #(.VOICES(V), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sample-level reference: plain integer sum, gain, floor divide, clamp
  function automatic void calc(input vvec_t v, input logic [V-1:0] en, input logic [7:0] g,
                               output logic [OW-1:0] s, output bit c);
    longint sum = 0;
    longint q;
    for (int i = 0; i < V; i++)
      if (en[i]) sum += longint'($signed(v[i]));
    q = (sum * longint'(g)) >>> (7 + IW - OW);
    c = 1'b0;
    if (q > 64'sd8388607) begin q = 64'sd8388607; c = 1'b1; end
    if (q < -64'sd8388608) begin q = -64'sd8388608; c = 1'b1; end
    s = q[OW-1:0];
  endfunction

  function automatic vvec_t fill(input logic [IW-1:0] x);
    vvec_t r;
    for (int i = 0; i < V; i++) r[i] = x;
    return r;
  endfunction

  // Model state: pending result countdown plus the held sample
  bit              busy = 0;
  int              cnt = 0;
  bit              m_valid = 0;
  bit              m_overrun = 0;
  logic [OW-1:0]   m_sample = '0;
  bit              m_clip = 0;
  logic [OW-1:0]   pend_s = '0;
  bit              pend_c = 0;

  always begin
    bit xfer;
    bit acc;
    @(posedge clk);
    if (rst) begin
      busy = 0; cnt = 0; m_valid = 0; m_overrun = 0; m_sample = '0; m_clip = 0;
    end else begin
      xfer      = m_valid && vif.out_ready;
      acc       = vif.sample_tick && !busy && (!m_valid || xfer);
      m_overrun = vif.sample_tick && !acc;
      if (xfer) m_valid = 0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 0; m_valid = 1; m_sample = pend_s; m_clip = pend_c;
        end
      end
      if (acc) begin
        busy = 1;
        cnt  = V + 1;
        calc(vif.voices, vif.voice_enable, vif.master_gain, pend_s, pend_c);
      end
    end
    #3;
    chk("valid", longint'(vif.out_valid), longint'(m_valid));
    chk("overrun", longint'(vif.overrun), longint'(m_overrun));
    if (m_valid || rst) begin
      chk("sample", longint'(vif.out_sample), longint'(m_sample));
      chk("clip", longint'(vif.clip), longint'(m_clip));
    end
  end

  task automatic drive_tick(input vvec_t v, input logic [V-1:0] en, input logic [7:0] g);
    @(negedge clk);
    vif.voices = v; vif.voice_enable = en; vif.master_gain = g; vif.sample_tick = 1'b1;
    @(negedge clk);
    vif.sample_tick = 1'b0;
  endtask

  // Counts edges after the tick edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      #4;
      if (vif.out_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  int lat;
  int nvalid;
  vvec_t vmask;

  initial begin
    rst = 1'b1;
    vif.sample_tick = 1'b0; vif.voices = '0; vif.voice_enable = '0;
    vif.master_gain = 8'd0; vif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", longint'(vif.out_valid), 0);
    chk("rst_sample", longint'(vif.out_sample), 0);
    rst = 1'b0;
    vif.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Unity sum, latency and single-cycle valid
    drive_tick(fill(32'd1000), 8'hFF, 8'd128);
    wait_valid(lat);
    chk("unity_latency", lat, 9);
    chk("unity_sample", longint'(vif.out_sample), 31);
    chk("unity_clip", longint'(vif.clip), 0);
    @(posedge clk); #4;
    chk("unity_one_cycle", longint'(vif.out_valid), 0);

    drive_tick(fill(32'h7FFFFFFF), 8'hFF, 8'd255);
    wait_valid(lat);
    chk("sat_pos_sample", longint'(vif.out_sample), longint'(24'h7FFFFF));
    chk("sat_pos_clip", longint'(vif.clip), 1);

    drive_tick(fill(32'h80000000), 8'hFF, 8'd255);
    wait_valid(lat);
    chk("sat_neg_sample", longint'(vif.out_sample), longint'(24'h800000));
    chk("sat_neg_clip", longint'(vif.clip), 1);

    vmask = '0; vmask[0] = 32'hFFFFFFFF;
    drive_tick(vmask, 8'hFF, 8'd128);
    wait_valid(lat);
    chk("floor_minus1", longint'(vif.out_sample), longint'(24'hFFFFFF));

    vmask = fill(32'd1000000); vmask[0] = 32'd512;
    drive_tick(vmask, 8'h01, 8'd128);
    wait_valid(lat);
    chk("mask_sample", longint'(vif.out_sample), 2);

    // Live inputs scrambled during ACCUM must not leak into the result
    drive_tick(fill(32'd1000), 8'hFF, 8'd128);
    for (int i = 0; i < 4; i++) begin
      vif.voices = fill($urandom); vif.voice_enable = 8'($urandom); vif.master_gain = 8'($urandom);
      @(negedge clk);
    end
    wait_valid(lat);
    chk("live_change_sample", longint'(vif.out_sample), 31);

    // Back-pressure with a dropped tick, then ready raised alongside a new tick
    @(negedge clk); vif.out_ready = 1'b0;
    drive_tick(fill(32'd1000), 8'hFF, 8'd128);
    wait_valid(lat);
    repeat (5) @(negedge clk);
    vif.sample_tick = 1'b1; vif.voices = fill(32'd5);
    @(posedge clk); #4;
    chk("hold_overrun", longint'(vif.overrun), 1);
    chk("hold_sample", longint'(vif.out_sample), 31);
    @(negedge clk); vif.sample_tick = 1'b0;
    @(posedge clk); #4;
    chk("hold_overrun_pulse", longint'(vif.overrun), 0);
    repeat (13) @(negedge clk);
    vmask = fill(32'd1000000); vmask[0] = 32'd512;
    vif.voices = vmask; vif.voice_enable = 8'h01; vif.master_gain = 8'd128;
    vif.out_ready = 1'b1; vif.sample_tick = 1'b1;
    @(posedge clk); #4;
    chk("xfer_tick_valid", longint'(vif.out_valid), 0);
    chk("xfer_tick_no_overrun", longint'(vif.overrun), 0);
    @(negedge clk); vif.sample_tick = 1'b0;
    wait_valid(lat);
    chk("xfer_tick_latency", lat, 9);
    chk("xfer_tick_sample", longint'(vif.out_sample), 2);

    // Reset while idx = 3
    drive_tick(fill(32'd777), 8'hFF, 8'd128);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrst_valid", longint'(vif.out_valid), 0);
    chk("midrst_sample", longint'(vif.out_sample), 0);
    chk("midrst_overrun", longint'(vif.overrun), 0);
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    drive_tick(fill(32'd1000), 8'hFF, 8'd128);
    wait_valid(lat);
    chk("post_rst_sample", longint'(vif.out_sample), 31);

    // Second tick five cycles after the first
    drive_tick(fill(32'd1000), 8'hFF, 8'd128);
    repeat (3) @(negedge clk);
    drive_tick(fill(32'd9), 8'hFF, 8'd128);
    #(-1 + 1);
    nvalid = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #4;
      if (vif.out_valid) begin
        nvalid++;
        chk("double_tick_sample", longint'(vif.out_sample), 31);
      end
    end
    chk("double_tick_count", nvalid, 1);

    // Randomized traffic with scrambled inputs every cycle
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < V; i++) begin
        case ($urandom_range(3))
          0: vif.voices[i] = $urandom;
          1: vif.voices[i] = 32'($signed($urandom_range(200000)) - 100000);
          2: vif.voices[i] = 32'h7FFFFFFF;
          default: vif.voices[i] = 32'h80000000 + 32'($urandom_range(1000));
        endcase
      end
      vif.voice_enable = 8'($urandom);
      vif.master_gain  = 8'($urandom);
      vif.out_ready    = ($urandom_range(9) < 7);
      vif.sample_tick  = ($urandom_range(5) == 0);
    end
    @(negedge clk);
    vif.sample_tick = 1'b0; vif.out_ready = 1'b1;
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
